// File: rtl/fft_pkg.sv
// Shared types and address generation for in-place radix-2 FFT stage sequencers.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5
  } state_t;

  // Widest address the generator handles; callers keep the low log2(N) bits.
  localparam int fft_aw_max_c = 20;
  localparam logic [fft_aw_max_c-1:0] fft_one_c = 1;

  typedef struct packed {
    logic [fft_aw_max_c-1:0] addr0;
    logic [fft_aw_max_c-1:0] addr1;
    logic [fft_aw_max_c-1:0] tw_addr;
  } fft_addr_t;

  // DIT butterfly k of stage s: partner distance is 2^s, twiddle index is
  // the position inside the group scaled up to the N/2-entry ROM.
  function automatic fft_addr_t fft_addr_gen(input logic [fft_aw_max_c-1:0] k,
                                             input logic [4:0] s,
                                             input logic [4:0] log2_n);
    logic [fft_aw_max_c-1:0] half;
    logic [fft_aw_max_c-1:0] pos;
    logic [fft_aw_max_c-1:0] grp;
    fft_addr_t r;
    half      = fft_one_c << s;
    pos       = k & (half - fft_one_c);
    grp       = k >> s;
    r.addr0   = (grp << (s + 5'd1)) | pos;
    r.addr1   = r.addr0 + half;
    r.tw_addr = pos << (log2_n - 5'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer.sv
// Sequences one radix-2 DIT stage over an external dual-port sample RAM,
// one butterfly in flight at a time, writing results back in place.
//
// state | meaning
// IDLE  | waiting for start; illegal stage index flags error and pulses done
// READ  | rd_en with x0/x1 addresses and twiddle index for butterfly k
// LATCH | RAM/ROM data captured into the butterfly operand registers
// ISSUE | bf_x_valid held until the butterfly accepts
// WAIT  | operands held stable until bf_y_valid
// WRITE | wr_en with results; last butterfly ends the stage
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int data_width_p   = 24,
  parameter int nr_of_q_bits_p = 12,
  parameter int fft_n_p        = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(fft_n_p)-1:0]  cr_stage,
  output logic                        busy,
  output logic                        done,
  output logic                        sr_stage_err,
  output logic                        rd_en,
  output logic [$clog2(fft_n_p)-1:0]  rd_addr0,
  output logic [$clog2(fft_n_p)-1:0]  rd_addr1,
  input  logic [data_width_p-1:0]     rd_x0_re,
  input  logic [data_width_p-1:0]     rd_x0_im,
  input  logic [data_width_p-1:0]     rd_x1_re,
  input  logic [data_width_p-1:0]     rd_x1_im,
  output logic [$clog2(fft_n_p)-2:0]  tw_addr,
  input  logic [data_width_p-1:0]     tw_re,
  input  logic [data_width_p-1:0]     tw_im,
  output logic                        bf_x_valid,
  input  logic                        bf_x_ready,
  input  logic                        bf_y_valid,
  output logic [data_width_p-1:0]     bf_x0_re,
  output logic [data_width_p-1:0]     bf_x0_im,
  output logic [data_width_p-1:0]     bf_x1_re,
  output logic [data_width_p-1:0]     bf_x1_im,
  output logic [data_width_p-1:0]     bf_tw_re,
  output logic [data_width_p-1:0]     bf_tw_im,
  input  logic [data_width_p-1:0]     bf_y0_re,
  input  logic [data_width_p-1:0]     bf_y0_im,
  input  logic [data_width_p-1:0]     bf_y1_re,
  input  logic [data_width_p-1:0]     bf_y1_im,
  input  logic                        bf_overflow,
  input  logic                        bf_underflow,
  output logic                        wr_en,
  output logic [$clog2(fft_n_p)-1:0]  wr_addr0,
  output logic [$clog2(fft_n_p)-1:0]  wr_addr1,
  output logic [data_width_p-1:0]     wr_y0_re,
  output logic [data_width_p-1:0]     wr_y0_im,
  output logic [data_width_p-1:0]     wr_y1_re,
  output logic [data_width_p-1:0]     wr_y1_im,
  output logic                        sr_overflow,
  output logic                        sr_underflow
);

  localparam int log2_n_c = $clog2(fft_n_p);
  localparam int kw_c     = log2_n_c - 1;
  localparam logic [log2_n_c-1:0] stage_lim_c = (log2_n_c)'(log2_n_c);
  // Fractional bits only matter inside the butterfly.
  localparam int unused_q_bits_c = nr_of_q_bits_p;

  state_t                  state_q;
  state_t                  state_d;
  logic [kw_c-1:0]         k_q;
  logic [4:0]              s_q;
  logic                    done_q;
  logic                    err_q;
  logic                    ovf_q;
  logic                    udf_q;
  logic [data_width_p-1:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q, tw_re_q, tw_im_q;
  logic [data_width_p-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  fft_addr_t               gen;
  logic                    stage_ok;
  logic                    last_bf;
  logic                    unused_addr_bits;

  assign stage_ok = (cr_stage < stage_lim_c);
  assign last_bf  = &k_q;

  // Addresses for the current butterfly from k and the latched stage.
  always_comb begin
    gen = fft_addr_gen((fft_aw_max_c)'(k_q), s_q, 5'(log2_n_c));
  end

  assign unused_addr_bits = &{1'b0, gen.addr0[fft_aw_max_c-1:log2_n_c],
                              gen.addr1[fft_aw_max_c-1:log2_n_c],
                              gen.tw_addr[fft_aw_max_c-1:kw_c]};

  // Address buses are only driven while their strobe is up, so idle and
  // reset leave every bus at zero.
  assign busy       = (state_q != IDLE);
  assign rd_en      = (state_q == READ);
  assign wr_en      = (state_q == WRITE);
  assign bf_x_valid = (state_q == ISSUE);
  assign rd_addr0   = rd_en ? gen.addr0[log2_n_c-1:0] : '0;
  assign rd_addr1   = rd_en ? gen.addr1[log2_n_c-1:0] : '0;
  assign tw_addr    = rd_en ? gen.tw_addr[kw_c-1:0]   : '0;
  assign wr_addr0   = wr_en ? gen.addr0[log2_n_c-1:0] : '0;
  assign wr_addr1   = wr_en ? gen.addr1[log2_n_c-1:0] : '0;

  assign done         = done_q;
  assign sr_stage_err = err_q;
  assign sr_overflow  = ovf_q;
  assign sr_underflow = udf_q;
  assign bf_x0_re = x0_re_q;
  assign bf_x0_im = x0_im_q;
  assign bf_x1_re = x1_re_q;
  assign bf_x1_im = x1_im_q;
  assign bf_tw_re = tw_re_q;
  assign bf_tw_im = tw_im_q;
  assign wr_y0_re = y0_re_q;
  assign wr_y0_im = y0_im_q;
  assign wr_y1_re = y1_re_q;
  assign wr_y1_im = y1_im_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && stage_ok) state_d = READ;
      READ:    state_d = LATCH;
      LATCH:   state_d = ISSUE;
      ISSUE:   if (bf_x_ready) state_d = WAIT;
      WAIT:    if (bf_y_valid) state_d = WRITE;
      WRITE:   state_d = last_bf ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Stage context, operand/result holding and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      x0_re_q <= '0;
      x0_im_q <= '0;
      x1_re_q <= '0;
      x1_im_q <= '0;
      tw_re_q <= '0;
      tw_im_q <= '0;
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (stage_ok) begin
              s_q   <= 5'(cr_stage);
              k_q   <= '0;
              ovf_q <= 1'b0;
              udf_q <= 1'b0;
              err_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        LATCH: begin
          x0_re_q <= rd_x0_re;
          x0_im_q <= rd_x0_im;
          x1_re_q <= rd_x1_re;
          x1_im_q <= rd_x1_im;
          tw_re_q <= tw_re;
          tw_im_q <= tw_im;
        end
        WAIT: begin
          if (bf_y_valid) begin
            y0_re_q <= bf_y0_re;
            y0_im_q <= bf_y0_im;
            y1_re_q <= bf_y1_re;
            y1_im_q <= bf_y1_im;
            ovf_q   <= ovf_q | bf_overflow;
            udf_q   <= udf_q | bf_underflow;
          end
        end
        WRITE: begin
          if (last_bf) done_q <= 1'b1;
          k_q <= k_q + (kw_c)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer with N=8, Q12, 24-bit samples.
// Contains behavioural RAM, twiddle ROM and a 3-cycle butterfly that
// re-reads its operands at the end of the pipeline.
module tb_fft_stage_sequencer;
  localparam int W = 24;
  localparam int Q = 12;
  localparam int N = 8;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] cr_stage = '0;
  logic busy, done, sr_stage_err, rd_en, wr_en;
  logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [1:0] tw_addr;
  logic [W-1:0] rd_x0_re, rd_x0_im, rd_x1_re, rd_x1_im, tw_re, tw_im;
  logic bf_x_valid, bf_y_valid, bf_overflow, bf_underflow;
  logic bf_x_ready = 1'b1;
  logic [W-1:0] bf_x0_re, bf_x0_im, bf_x1_re, bf_x1_im, bf_tw_re, bf_tw_im;
  logic [W-1:0] bf_y0_re, bf_y0_im, bf_y1_re, bf_y1_im;
  logic [W-1:0] wr_y0_re, wr_y0_im, wr_y1_re, wr_y1_im;
  logic sr_overflow, sr_underflow;

  logic [W-1:0] ram_re [N];
  logic [W-1:0] ram_im [N];
  logic [W-1:0] rom_re [N/2];
  logic [W-1:0] rom_im [N/2];

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int log_a0 [16];
  int log_a1 [16];
  int log_tw [16];
  int bfm_cnt = 0;

  fft_stage_sequencer #(.data_width_p(W), .nr_of_q_bits_p(Q), .fft_n_p(N)) dut (
    .clk(clk), .rst(rst), .start(start), .cr_stage(cr_stage),
    .busy(busy), .done(done), .sr_stage_err(sr_stage_err),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_x0_re(rd_x0_re), .rd_x0_im(rd_x0_im), .rd_x1_re(rd_x1_re), .rd_x1_im(rd_x1_im),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .bf_x_valid(bf_x_valid), .bf_x_ready(bf_x_ready), .bf_y_valid(bf_y_valid),
    .bf_x0_re(bf_x0_re), .bf_x0_im(bf_x0_im), .bf_x1_re(bf_x1_re), .bf_x1_im(bf_x1_im),
    .bf_tw_re(bf_tw_re), .bf_tw_im(bf_tw_im),
    .bf_y0_re(bf_y0_re), .bf_y0_im(bf_y0_im), .bf_y1_re(bf_y1_re), .bf_y1_im(bf_y1_im),
    .bf_overflow(bf_overflow), .bf_underflow(bf_underflow),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_y0_re(wr_y0_re), .wr_y0_im(wr_y0_im), .wr_y1_re(wr_y1_re), .wr_y1_im(wr_y1_im),
    .sr_overflow(sr_overflow), .sr_underflow(sr_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sat24(input longint v);
    if (v > MAXV) return W'(MAXV);
    if (v < MINV) return W'(MINV);
    return W'(v);
  endfunction

  // RAM and twiddle ROM, both one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x0_re <= ram_re[rd_addr0];
      rd_x0_im <= ram_im[rd_addr0];
      rd_x1_re <= ram_re[rd_addr1];
      rd_x1_im <= ram_im[rd_addr1];
      tw_re    <= rom_re[tw_addr];
      tw_im    <= rom_im[tw_addr];
    end
    if (wr_en) begin
      ram_re[wr_addr0] <= wr_y0_re;
      ram_im[wr_addr0] <= wr_y0_im;
      ram_re[wr_addr1] <= wr_y1_re;
      ram_im[wr_addr1] <= wr_y1_im;
    end
  end

  // Butterfly model: accepts, waits 3 cycles, then computes from the held operands.
  always @(posedge clk or posedge rst) begin
    longint x0r, x0i, pr, pi, a0r, a0i, a1r, a1i;
    if (rst) begin
      bfm_cnt <= 0;
      bf_y_valid <= 1'b0;
      bf_overflow <= 1'b0;
      bf_underflow <= 1'b0;
      bf_y0_re <= '0; bf_y0_im <= '0; bf_y1_re <= '0; bf_y1_im <= '0;
    end else begin
      bf_y_valid <= 1'b0;
      if (bfm_cnt == 0) begin
        if (bf_x_valid && bf_x_ready) begin
          bfm_cnt <= 3;
          acc_cnt <= acc_cnt + 1;
        end
      end else begin
        bfm_cnt <= bfm_cnt - 1;
        if (bfm_cnt == 1) begin
          x0r = longint'($signed(bf_x0_re));
          x0i = longint'($signed(bf_x0_im));
          pr = (longint'($signed(bf_x1_re)) * longint'($signed(bf_tw_re))
              - longint'($signed(bf_x1_im)) * longint'($signed(bf_tw_im))) >>> Q;
          pi = (longint'($signed(bf_x1_re)) * longint'($signed(bf_tw_im))
              + longint'($signed(bf_x1_im)) * longint'($signed(bf_tw_re))) >>> Q;
          a0r = x0r + pr; a0i = x0i + pi; a1r = x0r - pr; a1i = x0i - pi;
          bf_y0_re <= sat24(a0r); bf_y0_im <= sat24(a0i);
          bf_y1_re <= sat24(a1r); bf_y1_im <= sat24(a1i);
          bf_overflow  <= (a0r > MAXV) || (a0i > MAXV) || (a1r > MAXV) || (a1i > MAXV);
          bf_underflow <= (a0r < MINV) || (a0i < MINV) || (a1r < MINV) || (a1i < MINV);
          bf_y_valid <= 1'b1;
        end
      end
    end
  end

  // Event monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (rd_cnt < 16) begin
          log_a0[rd_cnt] = int'(rd_addr0);
          log_a1[rd_cnt] = int'(rd_addr1);
          log_tw[rd_cnt] = int'(tw_addr);
        end
        rd_cnt++;
      end
      if (wr_en) wr_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; acc_cnt = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin ram_re[i] = '0; ram_im[i] = '0; end
    for (int i = 0; i < N/2; i++) begin rom_re[i] = W'(4096); rom_im[i] = '0; end
  endtask

  task automatic do_start(input int s);
    @(negedge clk);
    start = 1'b1;
    cr_stage = 3'(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL %s: done not seen within 300 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vec_cnt++;
    if ({busy, done, sr_stage_err, rd_en, wr_en, bf_x_valid, sr_overflow, sr_underflow} !== 8'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, done, sr_stage_err, rd_en, wr_en, bf_x_valid, sr_overflow, sr_underflow});
    end
    vec_cnt++;
    if ({rd_addr0, rd_addr1, wr_addr0, wr_addr1, tw_addr, bf_x0_re, bf_tw_re, wr_y0_re, wr_y1_im} !== '0) begin
      err_cnt++;
      $display("FAIL reset_bus: addr/data buses not zero (rd_addr1=%0d bf_x0_re=%0d wr_y0_re=%0d)",
               rd_addr1, bf_x0_re, wr_y0_re);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stage0_addr();
    int e0[4] = '{0, 2, 4, 6};
    int e1[4] = '{1, 3, 5, 7};
    clear_mem();
    clear_logs();
    do_start(0);
    wait_done("stage0_done");
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL stage0_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    vec_cnt++;
    if (rd_cnt !== 4 || wr_cnt !== 4 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL stage0_counts: rd=%0d wr=%0d done=%0d want 4 4 1", rd_cnt, wr_cnt, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (log_a0[i] !== e0[i] || log_a1[i] !== e1[i] || log_tw[i] !== 0) begin
        err_cnt++;
        $display("FAIL stage0_addr k=%0d: got (%0d,%0d,tw %0d) want (%0d,%0d,tw 0)",
                 i, log_a0[i], log_a1[i], log_tw[i], e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_addr_patterns();
    int s2a0[4] = '{0, 1, 2, 3};
    int s2a1[4] = '{4, 5, 6, 7};
    int s2tw[4] = '{0, 1, 2, 3};
    int s1a0[4] = '{0, 1, 4, 5};
    int s1a1[4] = '{2, 3, 6, 7};
    int s1tw[4] = '{0, 2, 0, 2};
    clear_logs();
    do_start(2);
    wait_done("stage2_done");
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (log_a0[i] !== s2a0[i] || log_a1[i] !== s2a1[i] || log_tw[i] !== s2tw[i]) begin
        err_cnt++;
        $display("FAIL stage2_addr k=%0d: got (%0d,%0d,tw %0d) want (%0d,%0d,tw %0d)",
                 i, log_a0[i], log_a1[i], log_tw[i], s2a0[i], s2a1[i], s2tw[i]);
      end
    end
    clear_logs();
    do_start(1);
    wait_done("stage1_done");
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (log_a0[i] !== s1a0[i] || log_a1[i] !== s1a1[i] || log_tw[i] !== s1tw[i]) begin
        err_cnt++;
        $display("FAIL stage1_addr k=%0d: got (%0d,%0d,tw %0d) want (%0d,%0d,tw %0d)",
                 i, log_a0[i], log_a1[i], log_tw[i], s1a0[i], s1a1[i], s1tw[i]);
      end
    end
  endtask

  task automatic test_data();
    logic [W-1:0] exp_re[4] = '{W'(6144), W'(2048), W'(400), W'(-200)};
    logic [W-1:0] exp_im[4] = '{W'(0), W'(0), W'(150), W'(250)};
    clear_mem();
    ram_re[0] = W'(4096); ram_re[1] = W'(2048);
    ram_re[2] = W'(100);  ram_im[2] = W'(200);
    ram_re[3] = W'(300);  ram_im[3] = W'(-50);
    do_start(0);
    wait_done("data_done");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (ram_re[i] !== exp_re[i] || ram_im[i] !== exp_im[i]) begin
        err_cnt++;
        $display("FAIL data_ram[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                 $signed(ram_re[i]), $signed(ram_im[i]), $signed(exp_re[i]), $signed(exp_im[i]));
      end
    end
    vec_cnt++;
    if (sr_overflow !== 1'b0 || sr_underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL data_flags: ovf=%b udf=%b want 0 0", sr_overflow, sr_underflow);
    end
  endtask

  task automatic test_stall();
    bit seen = 0;
    clear_mem();
    clear_logs();
    ram_re[0] = W'(11); ram_im[0] = W'(22);
    ram_re[1] = W'(33); ram_im[1] = W'(44);
    bf_x_ready = 1'b0;
    do_start(0);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bf_x_valid) seen = 1;
      else @(negedge clk);
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL stall_valid_seen: bf_x_valid never rose within 20 cycles"); end
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (bf_x_valid !== 1'b1 ||
          {bf_x0_re, bf_x0_im, bf_x1_re, bf_x1_im, bf_tw_re, bf_tw_im} !==
          {W'(11), W'(22), W'(33), W'(44), W'(4096), W'(0)}) begin
        err_cnt++;
        $display("FAIL stall_hold cyc=%0d: valid=%b ops=(%0d,%0d,%0d,%0d,%0d,%0d) want 1 (11,22,33,44,4096,0)",
                 i, bf_x_valid, bf_x0_re, bf_x0_im, bf_x1_re, bf_x1_im, bf_tw_re, bf_tw_im);
      end
      @(negedge clk);
    end
    bf_x_ready = 1'b1;
    wait_done("stall_done");
    vec_cnt++;
    if (acc_cnt !== 4) begin err_cnt++; $display("FAIL stall_accepts: got %0d want 4", acc_cnt); end
  endtask

  task automatic test_overflow();
    clear_mem();
    ram_re[0] = W'(MAXV);
    ram_re[1] = W'(MAXV);
    do_start(0);
    wait_done("ovf_done");
    vec_cnt++;
    if (sr_overflow !== 1'b1 || sr_underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_set: ovf=%b udf=%b want 1 0", sr_overflow, sr_underflow);
    end
    clear_mem();
    do_start(0);
    vec_cnt++;
    if (sr_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear_on_start: got %b want 0", sr_overflow); end
    wait_done("ovf_clear_done");
  endtask

  task automatic test_illegal();
    int rd_before;
    clear_logs();
    rd_before = rd_cnt;
    do_start(3);
    vec_cnt++;
    if (done !== 1'b1 || sr_stage_err !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL illegal_resp: done=%b err=%b busy=%b want 1 1 0", done, sr_stage_err, busy);
    end
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (rd_cnt !== rd_before || sr_stage_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL illegal_no_access: rd_en count %0d err=%b want %0d 1", rd_cnt, sr_stage_err, rd_before);
    end
    do_start(0);
    wait_done("illegal_recover_done");
    vec_cnt++;
    if (sr_stage_err !== 1'b0) begin err_cnt++; $display("FAIL illegal_err_clear: got %b want 0", sr_stage_err); end
  endtask

  task automatic test_reset_in_wait();
    bit acc = 0;
    int wr_before;
    clear_mem();
    ram_re[0] = W'(5); ram_im[0] = W'(7);
    clear_logs();
    do_start(0);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (acc_cnt > 0) acc = 1;
    end
    vec_cnt++;
    if (!acc) begin err_cnt++; $display("FAIL rstwait_accept: no acceptance within 20 cycles"); end
    wr_before = wr_cnt;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({busy, done, rd_en, wr_en, bf_x_valid, sr_overflow} !== 6'b0 ||
        {bf_x0_re, bf_x0_im, rd_addr1, wr_addr1, tw_addr} !== '0) begin
      err_cnt++;
      $display("FAIL rstwait_outputs: busy=%b wr_en=%b bf_x0=(%0d,%0d) want all zero",
               busy, wr_en, bf_x0_re, bf_x0_im);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    vec_cnt++;
    if (wr_cnt !== wr_before || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstwait_no_write: wr=%0d busy=%b want %0d 0", wr_cnt, busy, wr_before);
    end
    clear_logs();
    do_start(0);
    wait_done("rstwait_restart_done");
    @(negedge clk);
    vec_cnt++;
    if (wr_cnt !== 4 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL rstwait_restart: wr=%0d done=%0d want 4 1", wr_cnt, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    clear_logs();
    do_start(0);
    repeat (3) @(negedge clk);
    do_start(2);
    wait_done("busy_start_done");
    @(negedge clk);
    vec_cnt++;
    if (done_cnt !== 1 || rd_cnt !== 4) begin
      err_cnt++;
      $display("FAIL busy_start_counts: done=%0d rd=%0d want 1 4", done_cnt, rd_cnt);
    end
    vec_cnt++;
    if (log_a1[1] !== 3 || log_a1[3] !== 7 || log_a0[2] !== 4) begin
      err_cnt++;
      $display("FAIL busy_start_stage: addr1[1]=%0d addr1[3]=%0d addr0[2]=%0d want 3 7 4",
               log_a1[1], log_a1[3], log_a0[2]);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_stage0_addr();
    test_addr_patterns();
    test_data();
    test_stall();
    test_overflow();
    test_illegal();
    test_reset_in_wait();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
